// File: rtl/wfifo_ingress_if.sv
// Bundles the ingress handshake and the FIFO write-side signals of wfifo_ingress.
// slave is the ingress block's view; master is the view of whatever surrounds it.
interface wfifo_ingress_if #(
  parameter int ADDRSIZE = 4,
  parameter int DSIZE    = 8
);
  logic                s_valid;
  logic [DSIZE-1:0]    s_data;
  logic                s_ready;
  logic                winc;
  logic [DSIZE-1:0]    wdata;
  logic                wfull;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   rptr;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   wlevel;
  logic                walmost_full;

  modport slave (
    input  s_valid, s_data, wfull, wptr, rptr,
    output s_ready, winc, wdata, wq2_rptr, wlevel, walmost_full
  );

  modport master (
    output s_valid, s_data, wfull, wptr, rptr,
    input  s_ready, winc, wdata, wq2_rptr, wlevel, walmost_full
  );
endinterface

// File: rtl/wfifo_ingress.sv
// Write-side ingress of an async FIFO: a two-entry skid buffer feeding the write port,
// plus read-pointer synchronization and a registered fill level / almost-full flag.
module wfifo_ingress #(
  parameter int ADDRSIZE = 4,
  parameter int DSIZE    = 8,
  parameter int AF_LEVEL = 12
) (
  input  logic           wclk,
  input  logic           wrst_n,
  wfifo_ingress_if.slave bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  localparam logic [ADDRSIZE:0] AF_THR = AF_LEVEL[ADDRSIZE:0];

  logic [ADDRSIZE:0] wq1;
  logic [ADDRSIZE:0] wq2;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] wlevel_q;
  logic              walmost_full_q;

  state_t            state;
  state_t            state_next;
  logic [DSIZE-1:0]  main_data;
  logic [DSIZE-1:0]  skid_data;
  logic              main_valid;
  logic              s_ready_q;
  logic              accept;
  logic              drain;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // rptr enters wq1 directly so the first flop is the only one that can go metastable
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= bus.rptr;
      wq2 <= wq1;
    end
  end

  assign rbin       = gray2bin(wq2);
  assign wbin       = gray2bin(bus.wptr);
  assign level_next = wbin - rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q       <= '0;
      walmost_full_q <= 1'b0;
    end else begin
      wlevel_q       <= level_next;
      walmost_full_q <= (level_next >= AF_THR);
    end
  end

  assign bus.wq2_rptr     = wq2;
  assign bus.wlevel       = wlevel_q;
  assign bus.walmost_full = walmost_full_q;

  assign main_valid = (state != EMPTY);
  assign accept     = bus.s_valid & s_ready_q;
  assign drain      = main_valid & ~bus.wfull;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_next = TWO;
          load_skid  = 1'b1;
        end else if (drain) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (drain) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // s_ready is a flop on the next state, so it stays low for the first edge out of reset
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state     <= EMPTY;
      s_ready_q <= 1'b0;
    end else begin
      state     <= state_next;
      s_ready_q <= (state_next != TWO);
    end
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= bus.s_data;
      end else if (load_main_skid) begin
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_data <= bus.s_data;
      end
    end
  end

  assign bus.winc    = drain;
  assign bus.wdata   = main_data;
  assign bus.s_ready = s_ready_q;

endmodule

// File: tb/tb_wfifo_ingress.sv
// Self-checking bench for wfifo_ingress: scoreboard of accepted words vs. writes,
// plus directed checks of reset, backpressure, level decode and pointer wrap.
module tb_wfifo_ingress;

  localparam int ADDRSIZE = 4;
  localparam int DSIZE    = 8;

  logic wclk = 1'b0;
  logic wrst_n;
  int   total = 0;
  int   bad   = 0;
  logic [DSIZE-1:0] sbQ[$];

  wfifo_ingress_if #(.ADDRSIZE(ADDRSIZE), .DSIZE(DSIZE)) bus ();

  wfifo_ingress #(.ADDRSIZE(ADDRSIZE), .DSIZE(DSIZE), .AF_LEVEL(12)) dut (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .bus    (bus)
  );

  always #5 wclk = ~wclk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic nextCycle();
    @(negedge wclk);
  endtask

  // Words are pushed when the handshake completes and popped on every winc
  task automatic applyStimulus(input logic [7:0] base, input int count, input int stallAt);
    int sent = 0;
    int cyc = 0;
    int runLen = 0;
    int maxRun = 0;
    int wincs = 0;
    logic stall;
    while ((sent < count || sbQ.size() != 0) && cyc < 200) begin
      stall       = (stallAt >= 0) && (cyc >= stallAt) && (cyc < stallAt + 3);
      bus.s_valid = (sent < count);
      bus.s_data  = base + 8'(sent);
      bus.wfull   = stall;
      #1;
      if (stall) begin
        checkOutput("stall_winc", 32'(bus.winc), 32'd0);
        checkOutput("stall_ready", 32'(bus.s_ready), (cyc == stallAt) ? 32'd1 : 32'd0);
      end
      if (bus.winc) begin
        wincs++;
        runLen++;
        if (runLen > maxRun) maxRun = runLen;
        if (sbQ.size() == 0) checkOutput("winc_spurious", 32'(bus.winc), 32'd0);
        else checkOutput("wdata", 32'(bus.wdata), 32'(sbQ.pop_front()));
      end else begin
        runLen = 0;
      end
      if (bus.s_valid && bus.s_ready) begin
        sbQ.push_back(bus.s_data);
        sent++;
      end
      nextCycle();
      cyc++;
    end
    checkOutput("stream_done", 32'(cyc < 200), 32'd1);
    checkOutput("winc_count", 32'(wincs), 32'(count));
    if (stallAt < 0) checkOutput("throughput", 32'(maxRun), 32'(count));
    bus.s_valid = 1'b0;
    bus.wfull   = 1'b0;
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.wfull   = 1'b0;
    bus.wptr    = '0;
    bus.rptr    = 5'b10101;
    wrst_n      = 1'b0;
    nextCycle();
    nextCycle();
    checkOutput("rst_winc", 32'(bus.winc), 32'd0);
    checkOutput("rst_wdata", 32'(bus.wdata), 32'd0);
    checkOutput("rst_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("rst_wq2", 32'(bus.wq2_rptr), 32'd0);
    checkOutput("rst_level", 32'(bus.wlevel), 32'd0);
    checkOutput("rst_af", 32'(bus.walmost_full), 32'd0);

    wrst_n = 1'b1;
    #1;
    checkOutput("rel_ready0", 32'(bus.s_ready), 32'd0);
    nextCycle();
    checkOutput("rel_ready1", 32'(bus.s_ready), 32'd1);
    checkOutput("rel_wq2_e1", 32'(bus.wq2_rptr), 32'd0);
    nextCycle();
    checkOutput("rel_wq2_e2", 32'(bus.wq2_rptr), 32'h15);

    bus.rptr = '0;
    repeat (3) nextCycle();
    checkOutput("zero_level", 32'(bus.wlevel), 32'd0);

    applyStimulus(8'h00, 16, -1);
    applyStimulus(8'h10, 16, 4);

    // Level decode and almost-full threshold
    bus.wptr = 5'b01110;
    nextCycle();
    checkOutput("lvl11", 32'(bus.wlevel), 32'd11);
    checkOutput("af11", 32'(bus.walmost_full), 32'd0);
    bus.wptr = 5'b01010;
    nextCycle();
    checkOutput("lvl12", 32'(bus.wlevel), 32'd12);
    checkOutput("af12", 32'(bus.walmost_full), 32'd1);
    bus.wptr = 5'b11000;
    nextCycle();
    checkOutput("lvl16", 32'(bus.wlevel), 32'd16);
    checkOutput("af16", 32'(bus.walmost_full), 32'd1);

    // Wrap: read pointer takes three edges to reach the level
    bus.wptr = 5'b00011;
    bus.rptr = 5'b10001;
    nextCycle();
    checkOutput("wrap_e1", 32'(bus.wlevel), 32'd2);
    nextCycle();
    checkOutput("wrap_e2", 32'(bus.wlevel), 32'd2);
    nextCycle();
    checkOutput("wrap_e3", 32'(bus.wlevel), 32'd4);
    checkOutput("wrap_af", 32'(bus.walmost_full), 32'd0);

    // Fill the skid buffer under stall, then reset mid-transfer
    bus.wptr    = '0;
    bus.rptr    = '0;
    bus.s_valid = 1'b1;
    bus.wfull   = 1'b1;
    bus.s_data  = 8'hC1;
    nextCycle();
    bus.s_data  = 8'hC2;
    nextCycle();
    checkOutput("fill_ready", 32'(bus.s_ready), 32'd0);
    bus.wfull = 1'b0;
    wrst_n    = 1'b0;
    #1;
    checkOutput("mid_rst_winc", 32'(bus.winc), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.s_ready), 32'd0);
    checkOutput("mid_rst_wdata", 32'(bus.wdata), 32'd0);
    nextCycle();
    wrst_n = 1'b1;
    #1;
    checkOutput("post_rst_c0", 32'(bus.winc), 32'd0);
    nextCycle();
    checkOutput("post_rst_c1", 32'(bus.winc), 32'd0);
    bus.s_valid = 1'b0;
    sbQ.delete();
    nextCycle();
    applyStimulus(8'hA0, 4, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
